// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the byte-stream program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LEN,
        LOAD,
        CSUM,
        RUN,
        ERR
    } state_e;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = $clog2(LEN_BYTES > WORD_BYTES ? LEN_BYTES : WORD_BYTES);

    // States in which the loader is willing to take stream bytes.
    function automatic logic accepts_bytes(state_e s);
        return (s == LEN) || (s == LOAD) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by the length field and payload words.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic             clk_i,
    input  logic [IDX_W-1:0] byte_idx_i,
    input  logic             accept_i,
    input  logic [7:0]       byte_i,
    output logic [31:0]      word_o,
    output logic             word_done_o
);

    logic [31:0] word_q;

    // word_o already contains the byte being accepted, so the final byte is visible in word_o.
    always_comb begin
        word_o = word_q;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (byte_idx_i == IDX_W'(b)) begin
                word_o[8*b +: 8] = byte_i;
            end
        end
    end

    assign word_done_o = accept_i && (byte_idx_i == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk_i) begin
        if (accept_i) begin
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader that fills instruction memory and then releases the core.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reload,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          core_en,
    output logic          done,
    output logic          error
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e FILL_NEXT = CSUM;
`else
    localparam state_e FILL_NEXT = RUN;
`endif

    state_e           state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [AW:0]      word_idx_q, word_idx_d;
    logic [AW:0]      len_q, len_d;
    logic             s_ready_q, s_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [AW-1:0]    imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic        take;
    logic        pack_en;
    logic        pack_done;
    logic [31:0] pack_word;
    logic        last_fill;

    // reload discards any byte handshaked in the same cycle
    assign take    = s_valid && s_ready_q && !reload;
    assign pack_en = take && ((state_q == LEN) || (state_q == LOAD));

    prog_loader_byte_packer u_byte_packer (
        .clk_i       (clk),
        .byte_idx_i  (byte_idx_q),
        .accept_i    (pack_en),
        .byte_i      (s_data),
        .word_o      (pack_word),
        .word_done_o (pack_done)
    );

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        len_d        = len_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        last_fill    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            LEN: begin
                if (take) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (pack_done) begin
                        len_d = pack_word[AW:0];
                        if (pack_word == 32'd0) begin
                            state_d = FILL_NEXT;
                        end else if (pack_word > 32'(IMEM_DEPTH)) begin
                            state_d = ERR;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                // Leave LOAD only once the final write pulse is on the port.
                if (imem_we_q && (word_idx_q == len_q)) begin
                    state_d = FILL_NEXT;
                end
                if (take) begin
                    byte_idx_d = byte_idx_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ s_data;
`endif
                    if (pack_done) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[AW-1:0];
                        imem_wdata_d = pack_word;
                        word_idx_d   = word_idx_q + 1'b1;
                        last_fill    = (word_idx_d == len_q);
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                if (take) begin
                    state_d = (s_data == csum_q) ? RUN : ERR;
                end
            end
`endif
            default: ;
        endcase

        if (reload) begin
            state_d    = LEN;
            byte_idx_d = '0;
            word_idx_d = '0;
            len_d      = '0;
            imem_we_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end

        s_ready_d = accepts_bytes(state_d) && !reload && !last_fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LEN;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            len_q        <= '0;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            len_q        <= len_d;
            s_ready_q    <= s_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = (state_q != RUN);
    assign core_en    = (state_q == RUN);
    assign done       = (state_q == RUN);
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle table for a 2-word image plus framing corner cases.
module tb_prog_loader;

    localparam int IMEM_DEPTH = 256;
    localparam int AW         = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reload = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          core_en;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    prog_loader #(.IMEM_DEPTH(IMEM_DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .reload     (reload),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .done       (done),
        .error      (error)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write log of the imem port, and a counter of back-to-back write strobes.
    logic [AW-1:0] wr_addr_log[$];
    logic [31:0]   wr_data_log[$];
    logic          prev_we = 1'b0;
    int            double_we = 0;

    always @(posedge clk) begin
        if (imem_we) begin
            wr_addr_log.push_back(imem_addr);
            wr_data_log.push_back(imem_wdata);
            if (prev_we) double_we <= double_we + 1;
        end
        prev_we <= imem_we;
    end

    typedef struct packed {
        logic          vld;
        logic [7:0]    data;
        logic          exp_rdy;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_wdata;
        logic          exp_en;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic w,
                                logic [AW-1:0] a, logic [31:0] wd, logic en);
        vec_t t;
        t.vld = v; t.data = d; t.exp_rdy = r; t.exp_we = w;
        t.exp_addr = a; t.exp_wdata = wd; t.exp_en = en;
        return t;
    endfunction

    task automatic do_reset();
        rst = 1'b1; reload = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int   guard = 0;
        logic acc = 1'b0;
        while (!acc && guard < 200) begin
            s_data  = b;
            s_valid = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            acc     = s_valid && s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL send_byte timeout: byte %0h not accepted, s_ready=%0b", b, s_ready);
        end
    endtask

    task automatic send_frame(input logic [31:0] words[$], input bit rnd);
        logic [31:0] n;
        logic [7:0]  x;
        n = words.size();
        x = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], rnd);
        foreach (words[w]) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(words[w][8*i +: 8], rnd);
                x = x ^ words[w][8*i +: 8];
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(x, rnd);
`endif
    endtask

    logic [31:0] img[$];
    logic [31:0] img4[4];

    initial begin
        tbl[0]  = mk(1, 8'h02, 1, 0, 8'd0, 32'h0, 0);
        tbl[1]  = mk(1, 8'h00, 1, 0, 8'd0, 32'h0, 0);
        tbl[2]  = mk(1, 8'h00, 1, 0, 8'd0, 32'h0, 0);
        tbl[3]  = mk(1, 8'h00, 1, 0, 8'd0, 32'h0, 0);
        tbl[4]  = mk(1, 8'h13, 1, 0, 8'd0, 32'h0, 0);
        tbl[5]  = mk(1, 8'h00, 1, 0, 8'd0, 32'h0, 0);
        tbl[6]  = mk(1, 8'h50, 1, 0, 8'd0, 32'h0, 0);
        tbl[7]  = mk(1, 8'h00, 1, 1, 8'd0, 32'h00500013, 0);
        tbl[8]  = mk(1, 8'h93, 1, 0, 8'd0, 32'h00500013, 0);
        tbl[9]  = mk(1, 8'h00, 1, 0, 8'd0, 32'h00500013, 0);
        tbl[10] = mk(1, 8'hA0, 1, 0, 8'd0, 32'h00500013, 0);
        tbl[11] = mk(1, 8'h00, 0, 1, 8'd1, 32'h00A00093, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        tbl[12] = mk(0, 8'h00, 1, 0, 8'd1, 32'h00A00093, 0);
        tbl[13] = mk(1, 8'h70, 0, 0, 8'd1, 32'h00A00093, 1);
`else
        tbl[12] = mk(1, 8'hFF, 0, 0, 8'd1, 32'h00A00093, 1);
        tbl[13] = mk(1, 8'hFF, 0, 0, 8'd1, 32'h00A00093, 1);
`endif

        // Reset state
        do_reset();
        check("rst s_ready", 32'(s_ready), 32'd0);
        check("rst imem_we", 32'(imem_we), 32'd0);
        check("rst imem_addr", 32'(imem_addr), 32'd0);
        check("rst imem_wdata", imem_wdata, 32'd0);
        check("rst core_rst", 32'(core_rst), 32'd1);
        check("rst core_en", 32'(core_en), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        idle(1);
        check("s_ready after reset", 32'(s_ready), 32'd1);

        // Cycle-exact 2-word image
        wr_addr_log.delete(); wr_data_log.delete();
        for (int i = 0; i < 14; i++) begin
            s_valid = tbl[i].vld;
            s_data  = tbl[i].data;
            @(posedge clk);
            #1;
            check($sformatf("tbl[%0d] s_ready", i), 32'(s_ready), 32'(tbl[i].exp_rdy));
            check($sformatf("tbl[%0d] imem_we", i), 32'(imem_we), 32'(tbl[i].exp_we));
            check($sformatf("tbl[%0d] imem_addr", i), 32'(imem_addr), 32'(tbl[i].exp_addr));
            check($sformatf("tbl[%0d] imem_wdata", i), imem_wdata, tbl[i].exp_wdata);
            check($sformatf("tbl[%0d] core_en", i), 32'(core_en), 32'(tbl[i].exp_en));
            check($sformatf("tbl[%0d] core_rst", i), 32'(core_rst), 32'(!tbl[i].exp_en));
            check($sformatf("tbl[%0d] done", i), 32'(done), 32'(tbl[i].exp_en));
            check($sformatf("tbl[%0d] error", i), 32'(error), 32'd0);
        end
        s_valid = 1'b0;
        check("tbl write count", 32'(wr_addr_log.size()), 32'd2);

        // Zero-length image
        do_reset();
        wr_addr_log.delete(); wr_data_log.delete();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("N=0 core_en before csum", 32'(core_en), 32'd0);
        send_byte(8'h00, 1'b0);
`endif
        check("N=0 core_en", 32'(core_en), 32'd1);
        check("N=0 done", 32'(done), 32'd1);
        idle(2);
        check("N=0 write count", 32'(wr_addr_log.size()), 32'd0);

        // Length overflow, then recovery by reload
        do_reset();
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        check("ovf error", 32'(error), 32'd1);
        check("ovf s_ready", 32'(s_ready), 32'd0);
        check("ovf core_rst", 32'(core_rst), 32'd1);
        s_valid = 1'b1; s_data = 8'h55;
        idle(1);
        s_valid = 1'b0;
        check("ovf error sticky", 32'(error), 32'd1);
        reload = 1'b1;
        idle(1);
        reload = 1'b0;
        check("reload error", 32'(error), 32'd0);
        check("reload s_ready first cycle", 32'(s_ready), 32'd0);
        check("reload core_rst", 32'(core_rst), 32'd1);
        idle(1);
        check("reload s_ready second cycle", 32'(s_ready), 32'd1);

        // Reload mid-word, coincident with a valid byte
        do_reset();
        wr_addr_log.delete(); wr_data_log.delete();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        s_valid = 1'b1; s_data = 8'h33; reload = 1'b1;
        idle(1);
        s_valid = 1'b0; reload = 1'b0;
        check("midword reload s_ready", 32'(s_ready), 32'd0);
        check("midword reload core_rst", 32'(core_rst), 32'd1);
        idle(3);
        check("midword no write", 32'(wr_addr_log.size()), 32'd0);
        img.delete();
        img.push_back(32'h00500013);
        send_frame(img, 1'b0);
        idle(3);
        check("fresh frame write count", 32'(wr_addr_log.size()), 32'd1);
        if (wr_addr_log.size() == 1) begin
            check("fresh frame addr", 32'(wr_addr_log[0]), 32'd0);
            check("fresh frame data", wr_data_log[0], 32'h00500013);
        end
        check("fresh frame core_en", 32'(core_en), 32'd1);

        // 4-word image with sparse s_valid
        do_reset();
        wr_addr_log.delete(); wr_data_log.delete();
        img4[0] = 32'h00500013; img4[1] = 32'h00A00093;
        img4[2] = 32'h002081B3; img4[3] = 32'h00000073;
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(img4[i]);
        send_frame(img, 1'b1);
        idle(3);
        check("rand write count", 32'(wr_addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_log.size()) begin
                check($sformatf("rand addr[%0d]", i), 32'(wr_addr_log[i]), 32'(i));
                check($sformatf("rand data[%0d]", i), wr_data_log[i], img4[i]);
            end
        end
        check("rand core_en", 32'(core_en), 32'd1);
        check("imem_we single-cycle pulses", 32'(double_we), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on a 1-word image
        do_reset();
        for (int i = 0; i < 8; i++) send_byte((i == 0) ? 8'h01 : 8'h00, 1'b0);
        do_reset();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h43, 1'b0);
        idle(1);
        check("csum ok done", 32'(done), 32'd1);
        check("csum ok core_en", 32'(core_en), 32'd1);
        do_reset();
        wr_addr_log.delete(); wr_data_log.delete();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h44, 1'b0);
        idle(1);
        check("csum bad error", 32'(error), 32'd1);
        check("csum bad core_en", 32'(core_en), 32'd0);
        check("csum bad word written", 32'(wr_addr_log.size()), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
